// File: rtl/pla_sop_pipe.sv
// Runtime-programmable AND-OR (sum-of-products) evaluator with a two-stage
// valid/ready pipeline. Masks are loaded through a config port while the pipe is idle.
module pla_sop_pipe #(
    parameter int N_IN    = 4,
    parameter int N_TERMS = 2,
    parameter int N_OUT   = 1,
    localparam int CFG_W  = (2*N_IN > N_TERMS) ? 2*N_IN : N_TERMS,
    localparam int A_MAX  = (N_TERMS > N_OUT) ? N_TERMS : N_OUT,
    localparam int CFG_AW = (A_MAX > 2) ? $clog2(A_MAX) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_OUT-1:0]  out_data,
    input  logic              cfg_we,
    input  logic              cfg_plane,
    input  logic [CFG_AW-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_wdata,
    output logic              cfg_ready
);

    logic [N_TERMS-1:0][2*N_IN-1:0] r_and;
    logic [N_OUT-1:0][N_TERMS-1:0]  r_or;
    logic                           r_s1_valid;
    logic [N_TERMS-1:0]             r_s1_terms;
    logic                           r_out_valid;
    logic [N_OUT-1:0]               r_out_data;

    logic                           w_cfg_fire;
    logic                           w_adv2;
    logic                           w_in_fire;
    logic [N_TERMS-1:0]             w_terms;
    logic [N_OUT-1:0]               w_or;
    logic                           w_unused;

    assign cfg_ready  = ~r_s1_valid & ~r_out_valid;
    assign w_cfg_fire = cfg_we & cfg_ready;
    assign w_adv2     = ~r_out_valid | out_ready;
    assign in_ready   = ~w_cfg_fire & (~r_s1_valid | w_adv2);
    assign w_in_fire  = in_valid & in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign w_unused   = ^cfg_wdata;

    // An all-zero mask is an unprogrammed term and must evaluate to 0, not 1.
    for (genvar t = 0; t < N_TERMS; t++) begin : g_term
        assign w_terms[t] = (|r_and[t])
                          & (&(~r_and[t][N_IN-1:0] | in_data))
                          & (&(~r_and[t][2*N_IN-1:N_IN] | ~in_data));
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_out
        assign w_or[o] = |(r_or[o] & r_s1_terms);
    end

    // Out-of-range addresses match no entry, so such writes fall through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_and <= '0;
            r_or  <= '0;
        end else if (w_cfg_fire) begin
            for (int t = 0; t < N_TERMS; t++)
                if (!cfg_plane && cfg_addr == CFG_AW'(t))
                    r_and[t] <= cfg_wdata[2*N_IN-1:0];
            for (int o = 0; o < N_OUT; o++)
                if (cfg_plane && cfg_addr == CFG_AW'(o))
                    r_or[o] <= cfg_wdata[N_TERMS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_terms <= '0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_terms <= w_terms;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_adv2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid)
                r_out_data <= w_or;
        end
    end

endmodule

// File: tb/tb_pla_sop_pipe.sv
// Directed bench for pla_sop_pipe: N_IN=4, N_TERMS=2, N_OUT=3 so that a
// 2-bit config address can point past both planes.
module tb_pla_sop_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_data;
    logic       cfg_we = 1'b0;
    logic       cfg_plane = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pla_sop_pipe #(.N_IN(4), .N_TERMS(2), .N_OUT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_plane(cfg_plane), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready)
    );

    // Drives one config write, holding cfg_we until it is accepted.
    task automatic cfg_write(input logic plane, input logic [1:0] addr, input logic [7:0] data);
        int n = 0;
        cfg_we = 1'b1; cfg_plane = plane; cfg_addr = addr; cfg_wdata = data;
        #1;
        while (!cfg_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!cfg_ready) begin
            total++; bad++;
            $display("FAIL cfg_timeout: cfg_ready stayed low, required 1");
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Sends one vector with out_ready high; returns the result and whether it
    // appeared exactly two edges after the handshake. Leaves the pipe empty.
    task automatic run_vec(input logic [3:0] v, output logic [2:0] got, output logic lat_ok);
        int n = 0;
        lat_ok = 1'b1;
        got = 'x;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = v;
        #1;
        while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
        if (!in_ready) lat_ok = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        if (out_valid !== 1'b0) lat_ok = 1'b0;
        @(negedge clk);
        if (out_valid !== 1'b1) lat_ok = 1'b0;
        got = out_data;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2:0] got; logic lat;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_cfg_ready: got %b want 1", cfg_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 3'b000) begin bad++; $display("FAIL rst_out_data: got %b want 000", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec(4'hF, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL unprog_F: got %b lat_ok=%b want 000 lat_ok=1", got, lat); end
    endtask

    task automatic test_sop();
        logic [2:0] got; logic lat;
        cfg_write(1'b0, 2'd0, 8'h03);
        cfg_write(1'b0, 2'd1, 8'h0C);
        cfg_write(1'b1, 2'd0, 8'h03);
        run_vec(4'b1110, got, lat);
        total++; if (!lat || got !== 3'b001) begin bad++; $display("FAIL sop_1110: got %b lat_ok=%b want 001 lat_ok=1", got, lat); end
        run_vec(4'b0100, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL sop_0100: got %b lat_ok=%b want 000 lat_ok=1", got, lat); end
        run_vec(4'b0011, got, lat);
        total++; if (!lat || got !== 3'b001) begin bad++; $display("FAIL sop_0011: got %b lat_ok=%b want 001 lat_ok=1", got, lat); end
    endtask

    task automatic test_complement();
        logic [2:0] got; logic lat;
        cfg_write(1'b0, 2'd0, 8'h10);
        cfg_write(1'b1, 2'd0, 8'h01);
        run_vec(4'b0000, got, lat);
        total++; if (!lat || got !== 3'b001) begin bad++; $display("FAIL comp_0000: got %b want 001", got); end
        run_vec(4'b0001, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL comp_0001: got %b want 000", got); end
        cfg_write(1'b0, 2'd0, 8'h11);
        run_vec(4'b0000, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL both_0000: got %b want 000", got); end
        run_vec(4'b0001, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL both_0001: got %b want 000", got); end
    endtask

    task automatic test_backpressure();
        logic [3:0] vecs [4];
        logic [2:0] exps [4];
        logic [2:0] got  [4];
        int sent = 0, rcv = 0;
        logic held_v = 1'b0;
        logic [2:0] held_d = '0;
        logic saw_drop = 1'b0;
        // out = {t0|t1, t1, t0} with t0 = in[0], t1 = in[1]
        cfg_write(1'b0, 2'd0, 8'h01);
        cfg_write(1'b0, 2'd1, 8'h02);
        cfg_write(1'b1, 2'd0, 8'h01);
        cfg_write(1'b1, 2'd1, 8'h02);
        cfg_write(1'b1, 2'd2, 8'h03);
        vecs = '{4'b0001, 4'b0010, 4'b0011, 4'b0000};
        exps = '{3'b101, 3'b110, 3'b111, 3'b000};
        got  = '{3'bx, 3'bx, 3'bx, 3'bx};
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (held_v) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_d) begin
                    bad++; $display("FAIL bp_hold c%0d: got v=%b d=%b want v=1 d=%b", c, out_valid, out_data, held_d);
                end
            end
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (sent < 4);
            in_data   = (sent < 4) ? vecs[sent] : 4'h0;
            #1;
            held_v = out_valid && !out_ready;
            held_d = out_data;
            if (in_valid && !in_ready) saw_drop = 1'b1;
            if (out_valid && out_ready) begin
                if (rcv < 4) got[rcv] = out_data;
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (rcv !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", rcv); end
        total++; if (!saw_drop) begin bad++; $display("FAIL bp_in_ready_drop: got never-low want low during stall"); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got[i] !== exps[i]) begin bad++; $display("FAIL bp_data%0d: got %b want %b", i, got[i], exps[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_cfg_contention();
        logic [2:0] got; logic lat;
        // Write attempted while a result sits at the output: must be ignored.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'b0001;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        cfg_we = 1'b1; cfg_plane = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL busy_cfg_ready%0d: got %b want 0", i, cfg_ready); end
            total++; if (out_valid !== 1'b1 || out_data !== 3'b101) begin bad++; $display("FAIL busy_hold%0d: got v=%b d=%b want v=1 d=101", i, out_valid, out_data); end
            @(negedge clk);
        end
        cfg_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        run_vec(4'b0001, got, lat);
        total++; if (!lat || got !== 3'b101) begin bad++; $display("FAIL busy_mask_kept: got %b want 101", got); end

        // Config and input together on an empty pipe: config first, input uses new mask.
        cfg_we = 1'b1; cfg_plane = 1'b0; cfg_addr = 2'd0; cfg_wdata = 8'h02;
        in_valid = 1'b1; in_data = 4'b0010;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL both_in_ready: got %b want 0", in_ready); end
        total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL both_cfg_ready: got %b want 1", cfg_ready); end
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL next_in_ready: got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || out_data !== 3'b111) begin bad++; $display("FAIL new_mask_used: got v=%b d=%b want v=1 d=111", out_valid, out_data); end
        @(negedge clk);

        // Address 3 is past both planes: zero writes there must not touch anything.
        cfg_write(1'b0, 2'd3, 8'h00);
        cfg_write(1'b1, 2'd3, 8'h00);
        run_vec(4'b0010, got, lat);
        total++; if (!lat || got !== 3'b111) begin bad++; $display("FAIL oob_0010: got %b want 111", got); end
        run_vec(4'b0001, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL oob_0001: got %b want 000", got); end
    endtask

    task automatic test_reset_mid();
        logic [2:0] got; logic lat;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 3'b000) begin bad++; $display("FAIL arst_out_data: got %b want 000", out_data); end
        total++; if (cfg_ready !== 1'b1 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready: got cfg=%b in=%b want 1 1", cfg_ready, in_ready); end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stale_out%0d: got %b want 0", i, out_valid); end
        end
        run_vec(4'b0010, got, lat);
        total++; if (!lat || got !== 3'b000) begin bad++; $display("FAIL masks_cleared: got %b lat_ok=%b want 000 lat_ok=1", got, lat); end
    endtask

    initial begin
        test_reset();
        test_sop();
        test_complement();
        test_backpressure();
        test_cfg_contention();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
